ks_pluck_feedback: RTL and testbench
====================================

Name: ks_pluck_feedback

Overview:
- Feedback and excitation stage of the Karplus-Strong string voice.
- Consumes the 16-bit sample leaving the configurable delay line.
- Applies a two-tap averaging low-pass filter with decay gain, and drives the next sample back into the delay-line input.
- On a pluck it injects an amplitude-scaled LFSR noise burst instead of feedback; it goes idle once the string has decayed to silence.

Parameters:
- SILENCE_THRESH, 4, magnitude at or below which a filtered sample counts as silent.
- SILENCE_CYCLES, 1024, consecutive silent samples that end RING (range 1..65535).
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset (must be non-zero).

Ports:
- clk  in  1  sample clock; one sample is processed per cycle.
- reset_n  in  1  synchronous active-low reset.
- pluck  in  1  pluck request, level-sampled each cycle.
- pluck_len  in  8  noise burst length in samples; 0 is treated as 1.
- amplitude  in  8  burst gain, unsigned Q0.8.
- decay  in  8  feedback gain, unsigned Q0.8.
- dl_q  in  16  signed sample from the delay-line output.
- dl_d  out  16  signed sample to the delay-line input.
- audio_out  out  16  signed voice output; always equal to dl_d.
- busy  out  1  high in EXCITE or RING.
- state  out  2  current state: 0 IDLE, 1 EXCITE, 2 RING.

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset (any cycle, including mid-burst):
  - state=IDLE; dl_d=audio_out=0; busy=0.
  - prev=0; burst counter=0; silence counter=0; lfsr=LFSR_SEED.
- prev register: captures dl_q every cycle, in all states.
- Filter result y:
  - sum = sext17(dl_q) + sext17(prev).
  - y = (sum * {1'b0,decay}) >>> 9, arithmetic shift (floor).
  - Result always fits 16 bits; no saturation logic.
- Noise value n = (signed(lfsr) * {1'b0,amplitude}) >>> 8, floor.
- LFSR: Galois, shifts right; if the pre-shift lsb is 1, XOR the shifted value with 16'hB400. It advances only on EXCITE cycles.
- dl_d is registered, so the stage adds exactly 1 cycle to the loop. Loop period = delay-line latency + 1; the team sets shift_register_length accordingly.
- IDLE:
  - dl_d<=0.
  - pluck=1 → EXCITE; burst counter<=max(pluck_len,1).
- EXCITE:
  - dl_d<=n; LFSR advances; counter decrements.
  - Counter reaching 0 after this cycle → RING; silence counter cleared.
  - pluck is ignored.
  - pluck_len is only sampled on entry.
- RING:
  - dl_d<=y.
  - If |y|<=SILENCE_THRESH, silence counter increments; otherwise it clears.
  - Counter reaching SILENCE_CYCLES → IDLE.
  - pluck=1 → EXCITE (re-pluck) with the same counter load. Re-pluck takes priority over the silence exit in the same cycle.
- Timing: pluck high at edge k in IDLE → noise samples appear on dl_d after edges k+1..k+N. The first filtered sample appears after edge k+N+1.
- decay and amplitude are used live every cycle; changing them mid-note is legal.
- |y| must treat -32768 correctly: use a 17-bit magnitude.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles during RING → dl_d=0, busy=0, state=0. The next burst starts from seed 16'hACE1.
- Burst: pluck_len=2, amplitude=255, one-cycle pluck → dl_d=-21196 then -7539, then state=RING. pluck_len=0 → exactly one noise sample.
- Filter arithmetic in RING, decay=255:
  - dl_q held at 1000 → dl_d=996.
  - dl_q held at -1000 → dl_d=-997.
  - decay=0 → dl_d=0.
- Silence exit: dl_q=0 in RING → busy drops after exactly 1024 cycles. A single |y|=5 sample at cycle 1000 restarts the count.
- Pluck priority: pluck during EXCITE leaves the burst length unchanged. pluck during RING restarts EXCITE with a fresh burst, and the LFSR continues from its current value (no reseed).
- Closed loop with a delay-line model of latency 99: the output period is 100 cycles, and peak amplitude decreases monotonically for decay=250.

Source files
------------

// File: rtl/ks_pluck_feedback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ks_pluck_feedback                                                          |
// | Karplus-Strong feedback/excitation stage: averaging low-pass with decay    |
// | gain, LFSR noise burst on pluck, silence detection back to idle.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ks_pluck_feedback #(
  parameter int          SILENCE_THRESH = 4,
  parameter int          SILENCE_CYCLES = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pluck,
  input  logic [7:0]         pluck_len,
  input  logic [7:0]         amplitude,
  input  logic [7:0]         decay,
  input  logic signed [15:0] dl_q,
  output logic signed [15:0] dl_d,
  output logic signed [15:0] audio_out,
  output logic               busy,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXCITE = 2'd1,
    S_RING   = 2'd2
  } state_t;

  localparam logic [16:0] c_thresh     = 17'(SILENCE_THRESH);
  localparam logic [15:0] c_sil_cycles = 16'(SILENCE_CYCLES);
  localparam logic [15:0] c_lfsr_taps  = 16'hB400;

  state_t             r_state, w_state_nxt;
  logic signed [15:0] r_prev;
  logic signed [15:0] r_dl_d, w_dl_d_nxt;
  logic [7:0]         r_burst, w_burst_nxt;
  logic [15:0]        r_sil, w_sil_nxt;
  logic [15:0]        r_lfsr, w_lfsr_nxt;

  // Filter datapath
  logic [16:0]        w_sum;
  logic signed [25:0] w_sum_ext, w_decay_ext, w_prod;
  logic signed [15:0] w_y;
  logic [16:0]        w_y_ext, w_y_mag;
  logic               w_silent;
  logic [15:0]        w_sil_inc;

  // Noise datapath
  logic signed [24:0] w_lfsr_ext, w_amp_ext, w_nprod;
  logic signed [15:0] w_noise;
  logic [15:0]        w_lfsr_adv;

  logic [7:0]         w_burst_load;
  logic [19:0]        w_unused_bits;

  assign w_sum       = {dl_q[15], dl_q} + {r_prev[15], r_prev};
  assign w_sum_ext   = {{9{w_sum[16]}}, w_sum};
  assign w_decay_ext = {18'd0, decay};
  assign w_prod      = w_sum_ext * w_decay_ext;
  assign w_y         = w_prod[24:9];

  // 17-bit magnitude so that the most negative value is handled correctly
  assign w_y_ext   = {w_y[15], w_y};
  assign w_y_mag   = w_y[15] ? (~w_y_ext + 17'd1) : w_y_ext;
  assign w_silent  = (w_y_mag <= c_thresh);
  assign w_sil_inc = r_sil + 16'd1;

  assign w_lfsr_ext = {{9{r_lfsr[15]}}, r_lfsr};
  assign w_amp_ext  = {17'd0, amplitude};
  assign w_nprod    = w_lfsr_ext * w_amp_ext;
  assign w_noise    = w_nprod[23:8];
  assign w_lfsr_adv = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'd0);

  assign w_burst_load  = (pluck_len == 8'd0) ? 8'd1 : pluck_len;
  assign w_unused_bits = {w_prod[25], w_prod[8:0], w_nprod[24], w_nprod[7:0], w_sum_ext[25]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_dl_d  <= '0;
      r_burst <= '0;
      r_sil   <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= dl_q;
      r_dl_d  <= w_dl_d_nxt;
      r_burst <= w_burst_nxt;
      r_sil   <= w_sil_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dl_d_nxt  = r_dl_d;
    w_burst_nxt = r_burst;
    w_sil_nxt   = r_sil;
    w_lfsr_nxt  = r_lfsr;
    case (r_state)
      S_IDLE: begin
        w_dl_d_nxt = '0;
        if (pluck) begin
          w_state_nxt = S_EXCITE;
          w_burst_nxt = w_burst_load;
        end
      end
      S_EXCITE: begin
        w_dl_d_nxt  = w_noise;
        w_lfsr_nxt  = w_lfsr_adv;
        w_burst_nxt = r_burst - 8'd1;
        if (r_burst <= 8'd1) begin
          w_state_nxt = S_RING;
          w_sil_nxt   = '0;
        end
      end
      S_RING: begin
        w_dl_d_nxt = w_y;
        w_sil_nxt  = w_silent ? w_sil_inc : 16'd0;
        // A new pluck wins over the silence exit
        if (pluck) begin
          w_state_nxt = S_EXCITE;
          w_burst_nxt = w_burst_load;
        end else if (w_silent && (w_sil_inc == c_sil_cycles)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dl_d_nxt  = '0;
      end
    endcase
  end

  assign dl_d      = r_dl_d;
  assign audio_out = r_dl_d;
  assign busy      = (r_state != S_IDLE);
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ks_pluck_feedback.sv
`default_nettype none
// Testbench for ks_pluck_feedback: directed vectors with hand-computed values
// plus a closed loop through a 99-cycle delay-line model.
module tb_ks_pluck_feedback;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pluck;
  logic [7:0]         pluck_len, amplitude, decay;
  logic signed [15:0] dl_q, dl_q_tb;
  logic signed [15:0] dl_d, audio_out;
  logic               busy;
  logic [1:0]         state;
  logic               loop_en;
  logic signed [15:0] sr [0:98];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ks_pluck_feedback dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pluck     (pluck),
    .pluck_len (pluck_len),
    .amplitude (amplitude),
    .decay     (decay),
    .dl_q      (dl_q),
    .dl_d      (dl_d),
    .audio_out (audio_out),
    .busy      (busy),
    .state     (state)
  );

  // Delay-line model, latency 99
  always @(posedge clk) begin
    if (!loop_en) begin
      for (int i = 0; i < 99; i++) sr[i] <= '0;
    end else begin
      sr[0] <= dl_d;
      for (int i = 1; i < 99; i++) sr[i] <= sr[i-1];
    end
  end
  assign dl_q = loop_en ? sr[98] : dl_q_tb;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(3);
    n_cmp++; if (dl_d !== 16'sd0) begin n_bad++; $display("FAIL reset_dl_d: got %0d expected 0", dl_d); end
    n_cmp++; if (audio_out !== 16'sd0) begin n_bad++; $display("FAIL reset_audio: got %0d expected 0", audio_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    reset_n = 1'b1;
  endtask

  task automatic test_burst;
    pluck_len = 8'd2; amplitude = 8'd255; decay = 8'd255; dl_q_tb = 16'sd0;
    step(1);
    pluck = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL burst_enter: state %0d expected 1", state); end
    pluck = 1'b0;
    step(1);
    n_cmp++; if (dl_d !== -16'sd21196) begin n_bad++; $display("FAIL burst_n0: got %0d expected -21196", dl_d); end
    step(1);
    n_cmp++; if (dl_d !== -16'sd7539) begin n_bad++; $display("FAIL burst_n1: got %0d expected -7539", dl_d); end
    n_cmp++; if (audio_out !== -16'sd7539) begin n_bad++; $display("FAIL burst_audio: got %0d expected -7539", audio_out); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL burst_ring: state %0d expected 2", state); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_busy: got %0b expected 1", busy); end
  endtask

  // Re-pluck from RING with pluck_len=0: one sample, LFSR not reseeded
  task automatic test_len0_repluck;
    pluck_len = 8'd0;
    pluck = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL repluck_enter: state %0d expected 1", state); end
    pluck = 1'b0;
    step(1);
    n_cmp++; if (dl_d !== 16'sd28870) begin n_bad++; $display("FAIL len0_sample: got %0d expected 28870", dl_d); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL len0_ring: state %0d expected 2", state); end
    step(1);
    n_cmp++; if (dl_d !== 16'sd0) begin n_bad++; $display("FAIL len0_filter: got %0d expected 0", dl_d); end
  endtask

  task automatic test_filter;
    decay = 8'd255; dl_q_tb = 16'sd1000;
    step(1);
    n_cmp++; if (dl_d !== 16'sd498) begin n_bad++; $display("FAIL filt_step: got %0d expected 498", dl_d); end
    step(1);
    n_cmp++; if (dl_d !== 16'sd996) begin n_bad++; $display("FAIL filt_pos: got %0d expected 996", dl_d); end
    dl_q_tb = -16'sd1000;
    step(2);
    n_cmp++; if (dl_d !== -16'sd997) begin n_bad++; $display("FAIL filt_neg: got %0d expected -997", dl_d); end
    decay = 8'd0;
    step(1);
    n_cmp++; if (dl_d !== 16'sd0) begin n_bad++; $display("FAIL filt_decay0: got %0d expected 0", dl_d); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL filt_state: state %0d expected 2", state); end
  endtask

  task automatic test_silence;
    decay = 8'd255; dl_q_tb = 16'sd1000;
    step(2);
    n_cmp++; if (dl_d !== 16'sd996) begin n_bad++; $display("FAIL sil_loud: got %0d expected 996", dl_d); end
    dl_q_tb = 16'sd6; decay = 8'd0;
    step(999);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL sil_999: state %0d expected 2", state); end
    decay = 8'd255;
    step(1);
    n_cmp++; if (dl_d !== 16'sd5) begin n_bad++; $display("FAIL sil_bump5: got %0d expected 5", dl_d); end
    decay = 8'd0;
    step(499);
    decay = 8'd171;
    step(1);
    n_cmp++; if (dl_d !== 16'sd4) begin n_bad++; $display("FAIL sil_thresh4: got %0d expected 4", dl_d); end
    decay = 8'd0;
    step(523);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sil_1023: busy %0b expected 1", busy); end
    step(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sil_exit_busy: got %0b expected 0", busy); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL sil_exit_state: got %0d expected 0", state); end
    dl_q_tb = 16'sd0;
  endtask

  // Pluck held and pluck_len changed during EXCITE must not alter the burst
  task automatic test_excite_priority;
    amplitude = 8'd128; pluck_len = 8'd3;
    pluck = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL pri_enter: state %0d expected 1", state); end
    pluck_len = 8'd10;
    step(1);
    n_cmp++; if (dl_d !== 16'sd7246) begin n_bad++; $display("FAIL pri_n0: got %0d expected 7246", dl_d); end
    step(1);
    n_cmp++; if (dl_d !== 16'sd3623) begin n_bad++; $display("FAIL pri_n1: got %0d expected 3623", dl_d); end
    pluck = 1'b0;
    step(1);
    n_cmp++; if (dl_d !== 16'sd1811) begin n_bad++; $display("FAIL pri_n2: got %0d expected 1811", dl_d); end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL pri_len: state %0d expected 2", state); end
  endtask

  task automatic test_reset_ring;
    decay = 8'd255; dl_q_tb = 16'sd1000;
    step(2);
    n_cmp++; if (dl_d !== 16'sd996) begin n_bad++; $display("FAIL rr_pre: got %0d expected 996", dl_d); end
    reset_n = 1'b0;
    step(3);
    n_cmp++; if (dl_d !== 16'sd0) begin n_bad++; $display("FAIL rr_dl_d: got %0d expected 0", dl_d); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_busy: got %0b expected 0", busy); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rr_state: got %0d expected 0", state); end
    reset_n = 1'b1; dl_q_tb = 16'sd0; amplitude = 8'd255; pluck_len = 8'd2;
    pluck = 1'b1;
    step(1);
    pluck = 1'b0;
    step(1);
    n_cmp++; if (dl_d !== -16'sd21196) begin n_bad++; $display("FAIL rr_seed_n0: got %0d expected -21196", dl_d); end
    step(1);
    n_cmp++; if (dl_d !== -16'sd7539) begin n_bad++; $display("FAIL rr_seed_n1: got %0d expected -7539", dl_d); end
  endtask

  task automatic test_closed_loop;
    logic [15:0] ml;
    int e [400];
    int got [400];
    int pk [4];
    int lv, s, bad, first;
    ml = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      lv = ml[15] ? (int'(ml) - 65536) : int'(ml);
      e[i] = (lv * 255) >>> 8;
      ml = ml[0] ? ((ml >> 1) ^ 16'hB400) : (ml >> 1);
    end
    for (int i = 100; i < 400; i++) begin
      s = e[i-100] + ((i > 100) ? e[i-101] : 0);
      e[i] = (s * 250) >>> 9;
    end
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1; dl_q_tb = 16'sd0; loop_en = 1'b1;
    step(2);
    pluck_len = 8'd100; amplitude = 8'd255; decay = 8'd250;
    pluck = 1'b1;
    step(1);
    pluck = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      got[i] = int'(dl_d);
    end
    for (int w = 0; w < 4; w++) begin
      bad = 0; first = -1; pk[w] = 0;
      for (int j = 0; j < 100; j++) begin
        if (got[w*100+j] != e[w*100+j]) begin
          bad++;
          if (first < 0) first = w*100+j;
        end
        lv = (got[w*100+j] < 0) ? -got[w*100+j] : got[w*100+j];
        if (lv > pk[w]) pk[w] = lv;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL loop_win%0d: sample %0d got %0d expected %0d (%0d bad)", w, first, got[first], e[first], bad);
      end
    end
    for (int w = 1; w < 4; w++) begin
      n_cmp++;
      if (!(pk[w] < pk[w-1])) begin
        n_bad++;
        $display("FAIL loop_peak%0d: peak %0d not below previous %0d", w, pk[w], pk[w-1]);
      end
    end
    loop_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pluck = 1'b0; pluck_len = 8'd0; amplitude = 8'd0;
    decay = 8'd0; dl_q_tb = 16'sd0; loop_en = 1'b0;
    test_reset;
    test_burst;
    test_len0_repluck;
    test_filter;
    test_silence;
    test_excite_priority;
    test_reset_ring;
    test_closed_loop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
